// File: rtl/lpf_pwm_pkg.sv
// -----------------------------------------------------------------------------
// lpf_pwm_pkg
// Shared types and constant helpers for the lpf_pwm_bank design.
//   sweep_dir_e : direction of the per-channel triangle sweep
//   thr_width   : width that holds duty*PERIOD without truncation
//   bar_thr     : lower bound of bar-graph segment idx (segments below the top)
// -----------------------------------------------------------------------------
package lpf_pwm_pkg;

   typedef enum logic {
      UP   = 1'b0,
      DOWN = 1'b1
   } sweep_dir_e;

   function automatic int thr_width(input int duty_w, input int period);
      return duty_w + $clog2(period);
   endfunction

   function automatic int bar_thr(input int idx, input int duty_w, input int bar_n);
      return ((idx + 1) * (1 << duty_w)) / bar_n;
   endfunction

endpackage

// File: rtl/lpf_pwm_chan.sv
// -----------------------------------------------------------------------------
// lpf_pwm_chan
// One channel of lpf_pwm_bank: shadow/active duty, optional triangle sweep,
// raw PWM, shift-based EMA filter and PWM of the filtered value.
// Optional feature macro: LPF_SWEEP_EN (sweep generator and sweep_sel_i).
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   cnt_i          shared period counter
//   boundary_i     high in the last cycle of the period
//   duty_i         programmed duty
//   duty_load_i    capture duty_i into the shadow register
//   sweep_sel_i    take the active duty from the sweep instead of the shadow
//   pwm_raw_o      registered PWM of the active duty
//   pwm_filt_o     registered PWM of the filtered value
//   filt_o         current filtered value (acc >> ALPHA_SHIFT)
// -----------------------------------------------------------------------------
module lpf_pwm_chan
   import lpf_pwm_pkg::*;
#(
   parameter int  DUTY_W      = 8,
   parameter int  PERIOD      = 12000,
   parameter int  ALPHA_SHIFT = 16,
   localparam int CNT_W       = $clog2(PERIOD)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [CNT_W-1:0]  cnt_i,
   input  logic              boundary_i,
   input  logic [DUTY_W-1:0] duty_i,
   input  logic              duty_load_i,
   input  logic              sweep_sel_i,
   output logic              pwm_raw_o,
   output logic              pwm_filt_o,
   output logic [DUTY_W-1:0] filt_o
);

   localparam int                TW       = thr_width(DUTY_W, PERIOD);
   localparam int                AW       = DUTY_W + ALPHA_SHIFT;
   localparam logic [TW-1:0]     PERIOD_T = TW'(PERIOD);
   localparam logic [DUTY_W-1:0] FS       = '1;
   localparam logic [AW-1:0]     FS_ACC   = AW'(FS);

   logic [DUTY_W-1:0] shadow_q, shadow_d;
   logic [DUTY_W-1:0] active_q, active_d;
   logic [DUTY_W-1:0] sweep_val;
   logic              use_sweep;
   logic [TW-1:0]     cnt_ext, raw_thr, filt_thr;
   logic              pwm_raw_q, pwm_raw_d;
   logic              pwm_filt_q, pwm_filt_d;
   logic [AW-1:0]     acc_q, acc_d;
   logic [DUTY_W-1:0] filt;

`ifdef LPF_SWEEP_EN
   sweep_dir_e        dir_q, dir_d;
   logic [DUTY_W-1:0] sweep_q, sweep_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dir_q   <= UP;
         sweep_q <= '0;
      end else begin
         dir_q   <= dir_d;
         sweep_q <= sweep_d;
      end
   end

   // Reaching an endpoint only flips the direction; the value is held for
   // that boundary, so each endpoint is seen for two periods.
   always_comb begin
      dir_d   = dir_q;
      sweep_d = sweep_q;
      if (boundary_i) begin
         unique case (dir_q)
            UP: begin
               if (sweep_q == FS) dir_d   = DOWN;
               else               sweep_d = sweep_q + DUTY_W'(1);
            end
            DOWN: begin
               if (sweep_q == '0) dir_d   = UP;
               else               sweep_d = sweep_q - DUTY_W'(1);
            end
            default: dir_d = UP;
         endcase
      end
   end

   always_comb begin
      use_sweep = sweep_sel_i;
      sweep_val = sweep_q;
   end
`else
   logic unused_sweep_sel;
   assign unused_sweep_sel = sweep_sel_i;
   assign use_sweep        = 1'b0;
   assign sweep_val        = '0;
`endif

   // shadow_d already carries a same-cycle load, so a load on the boundary
   // reaches the active duty without a period of delay.
   always_comb begin
      shadow_d = duty_load_i ? duty_i : shadow_q;
      active_d = active_q;
      if (boundary_i) active_d = use_sweep ? sweep_val : shadow_d;
   end

   assign filt     = acc_q[AW-1 -: DUTY_W];
   assign cnt_ext  = TW'(cnt_i);
   assign raw_thr  = (TW'(active_q) * PERIOD_T) >> DUTY_W;
   assign filt_thr = (TW'(filt) * PERIOD_T) >> DUTY_W;

   // acc settles at FS << ALPHA_SHIFT for a constant-high input, which fits AW.
   always_comb begin
      acc_d      = acc_q - (acc_q >> ALPHA_SHIFT) + (pwm_raw_q ? FS_ACC : '0);
      pwm_raw_d  = cnt_ext < raw_thr;
      pwm_filt_d = cnt_ext < filt_thr;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shadow_q   <= '0;
         active_q   <= '0;
         acc_q      <= '0;
         pwm_raw_q  <= 1'b0;
         pwm_filt_q <= 1'b0;
      end else begin
         shadow_q   <= shadow_d;
         active_q   <= active_d;
         acc_q      <= acc_d;
         pwm_raw_q  <= pwm_raw_d;
         pwm_filt_q <= pwm_filt_d;
      end
   end

   assign pwm_raw_o  = pwm_raw_q;
   assign pwm_filt_o = pwm_filt_q;
   assign filt_o     = filt;

endmodule

// File: rtl/lpf_pwm_bank.sv
// -----------------------------------------------------------------------------
// lpf_pwm_bank
// NCH channels of PWM -> EMA low-pass -> PWM, sharing one period counter,
// plus a thermometer bar graph of one selected channel's sampled value.
// Optional feature macro: LPF_SWEEP_EN (per-channel triangle sweep source).
// Ports:
//   CLK, RST     clock, synchronous active-high reset
//   duty_in      per-channel duty, channel k at [k*DUTY_W +: DUTY_W]
//   duty_load    capture duty_in into the shadow registers
//   sweep_sel    per-channel sweep source select
//   bar_sel      channel shown on the bar graph
//   pwm_raw      unfiltered PWM per channel
//   pwm_filt     PWM of the filtered value per channel
//   filt_val     filtered values sampled at each period boundary
//   filt_valid   one-cycle pulse when filt_val updates
//   bar          thermometer of the bar_sel channel (0 if out of range)
// -----------------------------------------------------------------------------
module lpf_pwm_bank
   import lpf_pwm_pkg::*;
#(
   parameter int  NCH         = 2,
   parameter int  DUTY_W      = 8,
   parameter int  PERIOD      = 12000,
   parameter int  ALPHA_SHIFT = 16,
   parameter int  BAR_N       = 8,
   localparam int SEL_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [NCH*DUTY_W-1:0] duty_in,
   input  logic                  duty_load,
   input  logic [NCH-1:0]        sweep_sel,
   input  logic [SEL_W-1:0]      bar_sel,
   output logic [NCH-1:0]        pwm_raw,
   output logic [NCH-1:0]        pwm_filt,
   output logic [NCH*DUTY_W-1:0] filt_val,
   output logic                  filt_valid,
   output logic [BAR_N-1:0]      bar
);

   localparam int                CNT_W = $clog2(PERIOD);
   localparam logic [DUTY_W-1:0] FS    = '1;

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  boundary;
   logic [NCH*DUTY_W-1:0] filt_w;
   logic [NCH*DUTY_W-1:0] filt_val_q, filt_val_d;
   logic                  filt_valid_q, filt_valid_d;
   logic [BAR_N-1:0]      bar_q, bar_d;
   logic [DUTY_W-1:0]     filt_arr [NCH];
   logic [DUTY_W-1:0]     sample;

   assign boundary = (cnt_q == CNT_W'(PERIOD - 1));

   for (genvar k = 0; k < NCH; k++) begin : g_chan
      lpf_pwm_chan #(
         .DUTY_W      (DUTY_W),
         .PERIOD      (PERIOD),
         .ALPHA_SHIFT (ALPHA_SHIFT)
      ) u_chan (
         .clk_i       (CLK),
         .rst_i       (RST),
         .cnt_i       (cnt_q),
         .boundary_i  (boundary),
         .duty_i      (duty_in[k*DUTY_W +: DUTY_W]),
         .duty_load_i (duty_load),
         .sweep_sel_i (sweep_sel[k]),
         .pwm_raw_o   (pwm_raw[k]),
         .pwm_filt_o  (pwm_filt[k]),
         .filt_o      (filt_w[k*DUTY_W +: DUTY_W])
      );

      assign filt_arr[k] = filt_val_q[k*DUTY_W +: DUTY_W];
   end

   always_comb begin
      cnt_d        = boundary ? '0 : cnt_q + CNT_W'(1);
      filt_val_d   = boundary ? filt_w : filt_val_q;
      filt_valid_d = boundary;
   end

   // The top segment lights only at full scale; the others at equal steps.
   always_comb begin
      sample = '0;
      if (int'(bar_sel) < NCH) sample = filt_arr[bar_sel];
      bar_d = '0;
      for (int unsigned i = 0; i < BAR_N; i++) begin
         if (i == BAR_N - 1) bar_d[i] = (sample == FS);
         else                bar_d[i] = (sample >= DUTY_W'(bar_thr(int'(i), DUTY_W, BAR_N)));
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q        <= '0;
         filt_val_q   <= '0;
         filt_valid_q <= 1'b0;
         bar_q        <= '0;
      end else begin
         cnt_q        <= cnt_d;
         filt_val_q   <= filt_val_d;
         filt_valid_q <= filt_valid_d;
         bar_q        <= bar_d;
      end
   end

   assign filt_val   = filt_val_q;
   assign filt_valid = filt_valid_q;
   assign bar        = bar_q;

endmodule
